// File: rtl/power_seq_pkg.sv
// Shared types and constants for the power-load sequencer: state encoding,
// LED status codes and the heartbeat divider tap.
package power_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD      = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_DONE      = 3'd4
  } seq_state_t;

  localparam logic [2:0] CODE_IDLE      = 3'd0;
  localparam logic [2:0] CODE_RAMP_UP   = 3'd1;
  localparam logic [2:0] CODE_HOLD      = 3'd2;
  localparam logic [2:0] CODE_RAMP_DOWN = 3'd3;
  localparam logic [2:0] CODE_DONE      = 3'd4;

  localparam int HEARTBEAT_BIT = 24;

  function automatic logic [2:0] state_code(input seq_state_t s);
    case (s)
      S_IDLE:      state_code = CODE_IDLE;
      S_RAMP_UP:   state_code = CODE_RAMP_UP;
      S_HOLD:      state_code = CODE_HOLD;
      S_RAMP_DOWN: state_code = CODE_RAMP_DOWN;
      S_DONE:      state_code = CODE_DONE;
      default:     state_code = CODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/power_seq_timer.sv
// Up-counter with a latched terminal value; tc is high while the count
// equals the terminal value. clr has priority over counting.
module power_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;

  // next count and terminal value
  always_comb begin
    if (load) begin
      lim_d = load_val;
    end else begin
      lim_d = lim_q;
    end
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
      lim_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

  assign tc = (cnt_q == lim_q);

endmodule

// File: rtl/power_load_sequencer.sv
// Ramps thermometer-coded consumer banks up, holds (optionally pulsed),
// then ramps down; all outputs are registered.
module power_load_sequencer
  import power_seq_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int CNT_W     = 32,
  parameter int PULSE_W   = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     dwell_cycles,
  input  logic [CNT_W-1:0]     hold_cycles,
  input  logic [PULSE_W-1:0]   pulse_on_cycles,
  input  logic [PULSE_W-1:0]   pulse_off_cycles,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           status
);

  localparam int LVL_W = $clog2(NUM_BANKS + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_BANKS);

  seq_state_t               state_q, state_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [PULSE_W:0]         phase_q, phase_d;
  logic [PULSE_W-1:0]       pulse_on_q, pulse_on_d, pulse_off_q, pulse_off_d;
  logic                     pulse_en_q, pulse_en_d, hold_inf_q, hold_inf_d;
  logic [NUM_BANKS-1:0]     bank_en_q, bank_en_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [3:0]               status_q, status_d;
  logic [HEARTBEAT_BIT-1:0] hb_cnt_q, hb_cnt_d;
  logic                     hb_q, hb_d;

  logic             accept_s, seq_change_s, dwell_tc_s, hold_tc_s;
  logic [CNT_W-1:0] dwell_m1_s;
  logic [PULSE_W:0] period_s;

  function automatic logic [NUM_BANKS-1:0] thermo(input logic [LVL_W-1:0] lvl);
    logic [NUM_BANKS-1:0] v;
    for (int i = 0; i < NUM_BANKS; i++) v[i] = (LVL_W'(i) < lvl);
    return v;
  endfunction

  // sequencing decisions: next state, level, pulse phase and latched config
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    phase_d     = phase_q;
    pulse_on_d  = pulse_on_q;
    pulse_off_d = pulse_off_q;
    pulse_en_d  = pulse_en_q;
    hold_inf_d  = hold_inf_q;
    accept_s    = 1'b0;
    period_s    = {1'b0, pulse_on_q} + {1'b0, pulse_off_q};
    if (abort) begin
      state_d = S_IDLE;
      level_d = LVL_W'(0);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            accept_s    = 1'b1;
            state_d     = S_RAMP_UP;
            level_d     = LVL_W'(1);
            pulse_on_d  = pulse_on_cycles;
            pulse_off_d = pulse_off_cycles;
            pulse_en_d  = (pulse_on_cycles != PULSE_W'(0)) && (pulse_off_cycles != PULSE_W'(0));
            hold_inf_d  = (hold_cycles == CNT_W'(0));
          end else begin
            accept_s = 1'b0;
          end
        end
        S_RAMP_UP: begin
          if (stop) begin
            state_d = S_RAMP_DOWN;
            level_d = level_q - LVL_W'(1);
          end else if (dwell_tc_s && (level_q < LVL_MAX)) begin
            level_d = level_q + LVL_W'(1);
          end else if (dwell_tc_s) begin
            state_d = S_HOLD;
            phase_d = (PULSE_W + 1)'(0);
          end else begin
            level_d = level_q;
          end
        end
        S_HOLD: begin
          if (stop || (!hold_inf_q && hold_tc_s)) begin
            state_d = S_RAMP_DOWN;
            level_d = level_q - LVL_W'(1);
          end else if (pulse_en_q && (phase_q == period_s - (PULSE_W + 1)'(1))) begin
            phase_d = (PULSE_W + 1)'(0);
          end else if (pulse_en_q) begin
            phase_d = phase_q + (PULSE_W + 1)'(1);
          end else begin
            phase_d = phase_q;
          end
        end
        S_RAMP_DOWN: begin
          if (level_q == LVL_W'(0)) begin
            state_d = S_DONE;
          end else if (dwell_tc_s) begin
            level_d = level_q - LVL_W'(1);
          end else begin
            level_d = level_q;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          level_d = LVL_W'(0);
        end
      endcase
    end
  end

  // timer control and next values of the registered outputs
  always_comb begin
    seq_change_s = (state_d != state_q) || (level_d != level_q);
    dwell_m1_s   = (dwell_cycles == CNT_W'(0)) ? CNT_W'(0) : dwell_cycles - CNT_W'(1);
    busy_d       = (state_d == S_RAMP_UP) || (state_d == S_HOLD) || (state_d == S_RAMP_DOWN);
    done_d       = (state_d == S_DONE);
    if ((state_d == S_HOLD) && pulse_en_q && (phase_d >= {1'b0, pulse_on_q})) begin
      bank_en_d = {NUM_BANKS{1'b0}};
    end else begin
      bank_en_d = thermo(level_d);
    end
    hb_cnt_d = hb_cnt_q + HEARTBEAT_BIT'(1);
    if (&hb_cnt_q) begin
      hb_d = ~hb_q;
    end else begin
      hb_d = hb_q;
    end
    status_d = {state_code(state_d), hb_d};
  end

  power_seq_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk_in),
    .rst      (rst),
    .load     (accept_s),
    .load_val (dwell_m1_s),
    .clr      (seq_change_s),
    .en       ((state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN)),
    .tc       (dwell_tc_s)
  );

  power_seq_timer #(.CNT_W(CNT_W)) u_hold (
    .clk      (clk_in),
    .rst      (rst),
    .load     (accept_s),
    .load_val (hold_cycles - CNT_W'(1)),
    .clr      (seq_change_s),
    .en       (state_q == S_HOLD),
    .tc       (hold_tc_s)
  );

  // state, config and output registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= S_IDLE;
      level_q     <= LVL_W'(0);
      phase_q     <= (PULSE_W + 1)'(0);
      pulse_on_q  <= PULSE_W'(0);
      pulse_off_q <= PULSE_W'(0);
      pulse_en_q  <= 1'b0;
      hold_inf_q  <= 1'b0;
      bank_en_q   <= {NUM_BANKS{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 4'd0;
      hb_cnt_q    <= HEARTBEAT_BIT'(0);
      hb_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      phase_q     <= phase_d;
      pulse_on_q  <= pulse_on_d;
      pulse_off_q <= pulse_off_d;
      pulse_en_q  <= pulse_en_d;
      hold_inf_q  <= hold_inf_d;
      bank_en_q   <= bank_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      status_q    <= status_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
    end
  end

  assign bank_en = bank_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign status  = status_q;

endmodule

// File: tb/tb_power_load_sequencer.sv
// Randomized bench for power_load_sequencer; expected outputs come from a
// closed-form timeline of each sequence (ramp/hold/ramp-down boundaries).
module tb_power_load_sequencer;

  localparam int NB  = 4;
  localparam int CW  = 32;
  localparam int PW  = 16;
  localparam int INF = 1 << 20;

  logic           clk_in = 1'b0;
  logic           rst, start, stop, abort;
  logic [CW-1:0]  dwell_cycles, hold_cycles;
  logic [PW-1:0]  pulse_on_cycles, pulse_off_cycles;
  logic [NB-1:0]  bank_en;
  logic           busy, done;
  logic [3:0]     status;

  int n_tests = 0;
  int n_fail  = 0;

  // sequence timeline: ramp-down entry, starting level, zero-level cycle, done cycle
  int m_d, m_on, m_off, m_h0, m_r0, m_l0, m_z, m_dn, m_kill;

  power_load_sequencer #(.NUM_BANKS(NB), .CNT_W(CW), .PULSE_W(PW)) dut (
    .clk_in           (clk_in),
    .rst              (rst),
    .start            (start),
    .stop             (stop),
    .abort            (abort),
    .dwell_cycles     (dwell_cycles),
    .hold_cycles      (hold_cycles),
    .pulse_on_cycles  (pulse_on_cycles),
    .pulse_off_cycles (pulse_off_cycles),
    .bank_en          (bank_en),
    .busy             (busy),
    .done             (done),
    .status           (status)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected outputs at cycle t after the start-sampling edge
  task automatic model_at(input int t, output logic [NB-1:0] be, output logic bz,
                          output logic dn, output logic [3:0] st);
    int lvl;
    logic [2:0] code;
    be = '0; bz = 1'b0; dn = 1'b0; code = 3'd0;
    if (t < 1 || (m_kill > 0 && t > m_kill) || t > m_dn) begin
      code = 3'd0;
    end else if (t < m_h0 && t < m_r0) begin
      code = 3'd1; bz = 1'b1;
      lvl = 1 + (t - 1) / m_d;
      be = NB'((1 << lvl) - 1);
    end else if (t < m_r0) begin
      code = 3'd2; bz = 1'b1;
      if (m_on > 0 && m_off > 0 && ((t - m_h0) % (m_on + m_off)) >= m_on) be = '0;
      else be = NB'((1 << NB) - 1);
    end else if (t <= m_z) begin
      code = 3'd3; bz = 1'b1;
      lvl = m_l0 - (t - m_r0) / m_d;
      be = NB'((1 << lvl) - 1);
    end else begin
      code = 3'd4; dn = 1'b1;
    end
    st = {code, 1'b0};
  endtask

  // run one sequence; s/a/r are the cycles carrying stop/abort/rst (0 = none)
  task automatic run_seq(input int d, input int h, input int on, input int off,
                         input int s, input int a, input int r, input bit scramble);
    int r0nat, lvl_s, tend;
    logic [NB-1:0] e_be;
    logic e_bz, e_dn;
    logic [3:0] e_st;
    m_d   = (d == 0) ? 1 : d;
    m_on  = on;
    m_off = off;
    m_h0  = 1 + NB * m_d;
    r0nat = (h > 0) ? m_h0 + h : INF;
    if (s >= 1 && s < r0nat) begin
      m_r0  = s + 1;
      lvl_s = (s < m_h0) ? 1 + (s - 1) / m_d : NB;
      m_l0  = lvl_s - 1;
    end else begin
      m_r0 = r0nat;
      m_l0 = NB - 1;
    end
    m_z  = m_r0 + m_l0 * m_d;
    m_dn = m_z + 1;
    m_kill = (a >= 1) ? a : 0;
    if (r >= 1 && (m_kill == 0 || r < m_kill)) m_kill = r;
    tend = (m_kill > 0 && m_kill < m_dn) ? m_kill + 2 : m_dn + 2;
    if (tend > 500) tend = 500;

    dwell_cycles     = CW'(d);
    hold_cycles      = CW'(h);
    pulse_on_cycles  = PW'(on);
    pulse_off_cycles = PW'(off);
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    if (scramble) begin
      dwell_cycles     = CW'($urandom_range(9, 0));
      hold_cycles      = CW'($urandom_range(9, 0));
      pulse_on_cycles  = PW'($urandom_range(4, 0));
      pulse_off_cycles = PW'($urandom_range(4, 0));
    end
    for (int t = 1; t <= tend; t++) begin
      stop  = (t == s);
      abort = (t == a);
      rst   = (t == r);
      @(negedge clk_in);
      model_at(t, e_be, e_bz, e_dn, e_st);
      check_eq($sformatf("bank_en d=%0d h=%0d t=%0d", d, h, t), 32'(bank_en), 32'(e_be));
      check_eq($sformatf("busy t=%0d", t), 32'(busy), 32'(e_bz));
      check_eq($sformatf("done t=%0d", t), 32'(done), 32'(e_dn));
      check_eq($sformatf("status t=%0d", t), 32'(status), 32'(e_st));
      @(posedge clk_in); #1;
    end
    stop = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int d, h, on, off, s, a, h0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0;
    dwell_cycles = '0; hold_cycles = '0; pulse_on_cycles = '0; pulse_off_cycles = '0;
    repeat (3) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    check_eq("reset bank_en", 32'(bank_en), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset status", 32'(status), 32'd0);
    @(posedge clk_in); #1;
    rst = 1'b0;

    run_seq(3, 5, 0, 0, 0, 0, 0, 1'b1);   // baseline ramp/hold/ramp-down
    run_seq(0, 3, 0, 0, 0, 0, 0, 1'b0);   // dwell 0 behaves as 1
    run_seq(1, 3, 0, 0, 0, 0, 0, 1'b0);
    run_seq(3, 0, 2, 3, 40, 0, 0, 1'b1);  // endless pulsed hold, then stop
    run_seq(3, 5, 0, 0, 5, 0, 0, 1'b0);   // stop at level 2
    run_seq(1, 10, 0, 0, 0, 8, 0, 1'b0);  // abort in HOLD

    // start together with stop in IDLE must not start a sequence
    start = 1'b1; stop = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_in);
      check_eq("start+stop busy", 32'(busy), 32'd0);
      check_eq("start+stop bank_en", 32'(bank_en), 32'd0);
      check_eq("start+stop status", 32'(status), 32'd0);
      @(posedge clk_in); #1;
    end

    run_seq(2, 1, 0, 0, 0, 0, 12, 1'b0);  // rst during RAMP_DOWN
    run_seq(3, 5, 0, 0, 0, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      d   = $urandom_range(4, 0);
      h   = $urandom_range(6, 0);
      on  = $urandom_range(3, 0);
      off = $urandom_range(3, 0);
      h0  = 1 + NB * ((d == 0) ? 1 : d);
      s   = ($urandom_range(1, 0) == 1) ? $urandom_range(h0 + h + 5, 1) : 0;
      if (h == 0 && s == 0) s = h0 + $urandom_range(8, 0);
      a   = ($urandom_range(6, 0) == 0) ? $urandom_range(30, 1) : 0;
      run_seq(d, h, on, off, s, a, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
